// File: rtl/param_alu_if.sv
// Command/result bundle for param_alu: operands, opcode and start from the
// requester; done, result, err and busy back from the ALU.
interface param_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               err;
    logic               busy;

    modport master (
        output A, B, op, start,
        input  done, result, err, busy
    );

    modport slave (
        input  A, B, op, start,
        output done, result, err, busy
    );
endinterface

// File: rtl/param_alu.sv
// Parameterised multi-cycle ALU: single-cycle add/and/xor/sub, MUL_LAT-cycle
// multiply, illegal-opcode error pulse, and a RELEASE state that waits for
// start to drop so a held request never re-executes.
module param_alu #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    param_alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_ILL = 3'b110,
        OP_RST = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RELEASE
    } state_e;

    state_e             state;
    state_e             state_next;
    op_e                op_in;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         cnt;
    logic               accept;
    logic               finish;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] calc;
    logic               done_q;
    logic               err_q;
    logic [2*WIDTH-1:0] result_q;

    assign op_in  = op_e'(bus.op);
    assign accept = (state == IDLE) && bus.start &&
                    (op_in != OP_NOP) && (op_in != OP_RST);
    // The counter holds k-1 at edge E(k), so a multiply finishes on E(MUL_LAT).
    assign finish = (state == EXEC) &&
                    ((op_q != OP_MUL) || (cnt == 4'(MUL_LAT - 1)));
    assign a_ext  = {{WIDTH{1'b0}}, a_q};
    assign b_ext  = {{WIDTH{1'b0}}, b_q};

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (finish) state_next = bus.start ? RELEASE : IDLE;
            RELEASE: if (!bus.start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        bus.busy = (state != IDLE);
    end

    // Result of the captured operation; illegal opcodes keep the old result.
    always_comb begin
        calc = result_q;
        case (op_q)
            OP_ADD:  calc = a_ext + b_ext;
            OP_AND:  calc = a_ext & b_ext;
            OP_XOR:  calc = a_ext ^ b_ext;
            OP_SUB:  calc = a_ext - b_ext;
            OP_MUL:  calc = a_ext * b_ext;
            default: calc = result_q;
        endcase
    end

    // Operand capture, multiply cycle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOP;
            cnt      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= finish;
            err_q  <= finish && (op_q == OP_ILL);
            if (finish) result_q <= calc;
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= op_in;
                cnt  <= '0;
            end else if ((state == EXEC) && (op_q == OP_MUL)) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu (WIDTH=8, MUL_LAT=3).
module tb_param_alu;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    param_alu_if #(.WIDTH(8)) bus ();

    param_alu #(
        .WIDTH   (8),
        .MUL_LAT (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command with start held until done, scramble the inputs after
    // the capture edge, then drop start and confirm the return to idle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int lat,
                          input logic [15:0] exp_r, input logic exp_e);
        bus.op = o; bus.A = a; bus.B = b; bus.start = 1'b1;
        tick();
        chk({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
        chk({tag, ".done_e0"}, 32'(bus.done), 32'd0);
        bus.A = ~a; bus.B = ~b; bus.op = 3'b011;
        for (int i = 1; i < lat; i++) begin
            tick();
            chk($sformatf("%s.done_e%0d", tag, i), 32'(bus.done), 32'd0);
        end
        tick();
        chk({tag, ".done"},   32'(bus.done),   32'd1);
        chk({tag, ".err"},    32'(bus.err),    32'(exp_e));
        chk({tag, ".result"}, 32'(bus.result), 32'(exp_r));
        bus.start = 1'b0;
        tick();
        chk({tag, ".done_after"}, 32'(bus.done),   32'd0);
        chk({tag, ".err_after"},  32'(bus.err),    32'd0);
        chk({tag, ".busy_after"}, 32'(bus.busy),   32'd0);
        chk({tag, ".hold"},       32'(bus.result), 32'(exp_r));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.A = '0; bus.B = '0;
        tick(); tick(); tick();
        chk("rst.done",   32'(bus.done),   32'd0);
        chk("rst.err",    32'(bus.err),    32'd0);
        chk("rst.busy",   32'(bus.busy),   32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        reset_n = 1'b1;

        run_op("add_ff_ff", 3'b001, 8'hFF, 8'hFF, 1, 16'h01FE, 1'b0);
        run_op("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0);
        run_op("sub_00_01", 3'b101, 8'h00, 8'h01, 1, 16'hFFFF, 1'b0);
        run_op("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0);
        run_op("sub_f0_3c", 3'b101, 8'hF0, 8'h3C, 1, 16'h00B4, 1'b0);
        run_op("xor_f0_3c", 3'b011, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0);
        run_op("mul_0d_0b", 3'b100, 8'h0D, 8'h0B, 3, 16'h008F, 1'b0);

        // start held for 10 cycles after done: one pulse, busy throughout.
        bus.op = 3'b001; bus.A = 8'h11; bus.B = 8'h22; bus.start = 1'b1;
        tick();
        tick();
        chk("hold.done",   32'(bus.done),   32'd1);
        chk("hold.result", 32'(bus.result), 32'h0033);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold.nodone%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("hold.busy%0d", i),   32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        tick();
        chk("hold.idle_busy", 32'(bus.busy), 32'd0);
        run_op("hold.second", 3'b001, 8'h01, 8'h02, 1, 16'h0003, 1'b0);

        // Reset at E2 of a multiply aborts it.
        bus.op = 3'b100; bus.A = 8'h03; bus.B = 8'h05; bus.start = 1'b1;
        tick();
        tick();
        chk("abort.done_e1", 32'(bus.done), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.start = 1'b0;
        chk("abort.done",   32'(bus.done),   32'd0);
        chk("abort.result", 32'(bus.result), 32'd0);
        chk("abort.busy",   32'(bus.busy),   32'd0);
        tick();
        chk("abort.done_e3", 32'(bus.done),   32'd0);
        chk("abort.res_e3",  32'(bus.result), 32'd0);
        run_op("post_rst_add", 3'b001, 8'h10, 8'h20, 1, 16'h0030, 1'b0);

        // Immediately after reset release, a command is accepted on the first edge.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run_op("first_edge_xor", 3'b011, 8'hA5, 8'h0F, 1, 16'h00AA, 1'b0);

        // Illegal opcode: done+err together, result unchanged.
        run_op("illegal", 3'b110, 8'h12, 8'h34, 1, 16'h00AA, 1'b1);

        // no_op and rst_op are ignored.
        for (int k = 0; k < 2; k++) begin
            bus.op = (k == 0) ? 3'b000 : 3'b111;
            bus.A = 8'h55; bus.B = 8'h66; bus.start = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk($sformatf("ignore%0d.done%0d", k, i), 32'(bus.done), 32'd0);
                chk($sformatf("ignore%0d.busy%0d", k, i), 32'(bus.busy), 32'd0);
            end
            chk($sformatf("ignore%0d.result", k), 32'(bus.result), 32'h00AA);
            bus.start = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MUL_LAT, default 3, giving the multiply latency in cycles (legal range 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B, unsigned.
REQ-007 The block SHALL have port op, input, 3 bits: opcode, encoded 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 sub, 110 illegal, 111 rst_op.
REQ-008 The block SHALL have port start, input, 1 bit: command request, held high by the driver until done.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: result of the last completed operation.
REQ-011 The block SHALL have port err, output, 1 bit: pulses together with done when the opcode is 110.
REQ-012 The block SHALL have port busy, output, 1 bit: high from acceptance of a command until the FSM returns to IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, EXEC, and RELEASE.
REQ-014 In IDLE, start=1 sampled with op in {001,010,011,100,101,110} SHALL capture A, B and op at that edge (edge E0) and move to EXEC.
REQ-015 In IDLE, start=1 with op 000 or 111 SHALL be ignored: no capture, no done, result unchanged, FSM remains in IDLE.
REQ-016 For add, and, xor, sub and the illegal opcode, done SHALL be registered high at edge E1, which is the one-cycle latency.
REQ-017 For mul, done SHALL be registered high at edge E(MUL_LAT).
REQ-018 A cycle counter SHALL run only in EXEC for mul and SHALL reset on every acceptance.
REQ-019 done SHALL be high for exactly one cycle per accepted command.
REQ-020 result SHALL update in the same cycle in which done goes high.
REQ-021 add SHALL produce A+B zero-extended to 2*WIDTH bits, with the carry appearing in bit WIDTH.
REQ-022 and and xor SHALL each produce the bitwise result zero-extended to 2*WIDTH bits.
REQ-023 sub SHALL produce (A-B) modulo 2^(2*WIDTH), i.e. a two's-complement wrap at 2*WIDTH bits.
REQ-024 mul SHALL produce the full unsigned 2*WIDTH-bit product.
REQ-025 The illegal opcode 110 SHALL pulse done=1 and err=1 together, and result SHALL hold its previous value.
REQ-026 Changes on A, B or op after E0 SHALL NOT affect the operation in flight.
REQ-027 When done is pulsed, the FSM SHALL go to RELEASE if start=1 at that edge, and otherwise to IDLE.
REQ-028 RELEASE SHALL stay in RELEASE while start=1 and SHALL go to IDLE on the first edge with start=0, so start held high after done never causes a re-execution.
REQ-029 If start drops during EXEC, the operation SHALL still complete and done SHALL still pulse, after which the FSM returns to IDLE.
REQ-030 busy SHALL be 1 in EXEC and RELEASE and 0 in IDLE.
REQ-031 Between operations, result SHALL hold its last value.

Reset
REQ-032 reset_n=0 sampled on any edge SHALL force state IDLE, done=0, err=0, busy=0, result=0 and the counter to 0, with priority over all other inputs.
REQ-033 Reset asserted during EXEC SHALL abort the operation, and no done SHALL be produced for it.
REQ-034 On the first edge with reset_n=1, the block SHALL be able to accept a command.

Verification (WIDTH=8, MUL_LAT=3)
REQ-035 The bench SHALL check: add A=0xFF, B=0xFF -> done at E1, result=0x01FE, err=0.
REQ-036 The bench SHALL check: mul A=0xFF, B=0xFF -> done=0 at E1 and E2, done=1 at E3, result=0xFE01.
REQ-037 The bench SHALL check: sub A=0x00, B=0x01 -> result=0xFFFF; and A=0xF0, B=0x3C -> result=0x0030; xor 0xF0,0x3C -> result=0x00CC.
REQ-038 The bench SHALL check: start held high for 10 cycles after done -> exactly one done pulse and busy=1 throughout; with start=0 for 1 cycle and then a new add, a second done occurs.
REQ-039 The bench SHALL check: reset_n=0 at E2 of a mul -> no done at E3, result=0x0000, busy=0.
REQ-040 The bench SHALL check: op=110 -> done=1 and err=1 at E1 with result unchanged; op=000 or op=111 with start held for 3 cycles -> no done, busy=0.
